// File: rtl/shared_src_arbiter_pkg.sv
// Shared types and defaults for the shared-source arbiter: FSM state encoding
// and the parameter defaults used by the top and the round-robin picker.
package shared_src_arbiter_pkg;

  localparam int DEFAULT_NUM_REQ    = 4;
  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int XFER_COUNT_W       = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2
  } arb_state_e;

endpackage : shared_src_arbiter_pkg

// File: rtl/shared_src_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after
// last_i+1, wrapping; the previous winner only wins again when it is alone.
module rr_pick
  import shared_src_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    // NOTE: every output and temporary gets a default first, so no path through the loop can infer a latch.
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand     = (int'(last_i) + i) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule : rr_pick

// File: rtl/shared_src_arbiter.sv
// Arbitrates NUM_REQ level requesters onto one shared producer: one outstanding
// fetch at a time, registered data broadcast, one-cycle ack to the winner.
module shared_src_arbiter
  import shared_src_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = DEFAULT_NUM_REQ,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_i,
  output logic [NUM_REQ-1:0]         ack_o,
  output logic [DATA_WIDTH-1:0]      dout_o,
  output logic                       src_req_o,
  input  logic                       src_ack_i,
  input  logic [DATA_WIDTH-1:0]      src_din_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
  output logic                       busy_o,
  output logic [XFER_COUNT_W-1:0]    xfer_count_o
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_e               state_q;
  logic [IDX_W-1:0]         grant_q;
  logic [IDX_W-1:0]         last_q;
  logic                     src_req_q;
  logic                     busy_q;
  logic [NUM_REQ-1:0]       ack_q;
  logic [DATA_WIDTH-1:0]    dout_q;
  logic [XFER_COUNT_W-1:0]  xfer_count_q;
  logic [XFER_COUNT_W-1:0]  xfer_count_d;

  logic                     pick_valid;
  logic [IDX_W-1:0]         pick_idx;
  logic                     capture;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req_i   (req_i),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // A producer ack only counts while a fetch is actually outstanding.
  assign capture = (state_q == FETCH) && src_ack_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking everywhere in clocked logic so every register samples pre-edge values.
      state_q   <= IDLE;
      grant_q   <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      src_req_q <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= '0;
      dout_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q   <= pick_idx;
            last_q    <= pick_idx;
            src_req_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= FETCH;
          end
        end
        FETCH: begin
          if (capture) begin
            dout_q    <= src_din_i;
            src_req_q <= 1'b0;
            ack_q     <= NUM_REQ'(1) << grant_q;
            state_q   <= DELIVER;
          end
        end
        DELIVER: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          src_req_q <= 1'b0;
          busy_q    <= 1'b0;
          ack_q     <= '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign xfer_count_d = xfer_count_q + XFER_COUNT_W'(capture);

  always_ff @(posedge clk) begin
    if (rst) xfer_count_q <= '0;
    else     xfer_count_q <= xfer_count_d;
  end

  assign ack_o        = ack_q;
  assign dout_o       = dout_q;
  assign src_req_o    = src_req_q;
  assign grant_idx_o  = grant_q;
  assign busy_o       = busy_q;
  assign xfer_count_o = xfer_count_q;

endmodule : shared_src_arbiter

// File: tb/tb_shared_src_arbiter.sv
// Bench for shared_src_arbiter: transaction-level model compared every cycle,
// directed scenarios with hand-computed expectations, reactive producer.
module tb_shared_src_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req_i;
  logic [N-1:0]  ack_o;
  logic [DW-1:0] dout_o;
  logic          src_req_o;
  logic          src_ack_i;
  logic [DW-1:0] src_din_i;
  logic [1:0]    grant_idx_o;
  logic          busy_o;
  logic [31:0]   xfer_count_o;

  shared_src_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .ack_o        (ack_o),
    .dout_o       (dout_o),
    .src_req_o    (src_req_o),
    .src_ack_i    (src_ack_i),
    .src_din_i    (src_din_i),
    .grant_idx_o  (grant_idx_o),
    .busy_o       (busy_o),
    .xfer_count_o (xfer_count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Producer and bookkeeping state, all owned by the stimulus process.
  logic [DW-1:0] prod_data = '0;
  int            prod_delay = 0;
  int            wait_cnt   = 0;
  logic          acked      = 1'b0;
  logic          stray_ack  = 1'b0;
  logic          cnt_preload = 1'b0;
  int            cyc = 0;
  int            sreq_cycles = 0;
  int            ack_seen = 0;
  int            log_port[$];
  logic [DW-1:0] log_data[$];
  int            log_cyc[$];

  // Transaction model: a grant opens a fetch, the producer ack closes it and
  // opens a one-cycle delivery, after which the source is free again.
  logic          m_fetch = 1'b0;
  logic          m_busy  = 1'b0;
  logic [N-1:0]  m_ack   = '0;
  logic [1:0]    m_grant = '0;
  int            m_last  = N - 1;
  logic [31:0]   m_cnt   = '0;
  logic [DW-1:0] m_dout  = '0;

  function automatic logic bit_at(input logic [N-1:0] v, input int pos);
    logic [N-1:0] sh;
    sh = v >> pos;
    return sh[0];
  endfunction

  function automatic int rr_model(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++)
      if (bit_at(req, (last + k) % N)) return (last + k) % N;
    return -1;
  endfunction

  function automatic int port_of(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[k]) return k;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_fetch <= 1'b0;
      m_busy  <= 1'b0;
      m_ack   <= '0;
      m_grant <= '0;
      m_last  <= N - 1;
      m_cnt   <= '0;
      m_dout  <= '0;
    end else if (cnt_preload) begin
      m_cnt <= 32'hFFFF_FFFF;
    end else if (m_ack != '0) begin
      m_ack  <= '0;
      m_busy <= 1'b0;
    end else if (m_fetch) begin
      if (src_ack_i) begin
        m_fetch <= 1'b0;
        m_ack   <= N'(1) << m_grant;
        m_dout  <= src_din_i;
        m_cnt   <= m_cnt + 32'd1;
      end
    end else if (rr_model(req_i, m_last) >= 0) begin
      m_fetch <= 1'b1;
      m_busy  <= 1'b1;
      m_grant <= 2'(rr_model(req_i, m_last));
      m_last  <= rr_model(req_i, m_last);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("model_ack",     64'(ack_o),        64'(m_ack));
    check("model_src_req", 64'(src_req_o),    64'(m_fetch));
    check("model_busy",    64'(busy_o),       64'(m_busy));
    check("model_grant",   64'(grant_idx_o),  64'(m_grant));
    check("model_dout",    64'(dout_o),       64'(m_dout));
    check("model_count",   64'(xfer_count_o), 64'(m_cnt));
  endtask

  // One clock: compare just after the rising edge, then drive at the falling edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    compare_all();
    if (src_req_o) sreq_cycles++;
    if (ack_o != '0) begin
      ack_seen++;
      log_port.push_back(port_of(ack_o));
      log_data.push_back(dout_o);
      log_cyc.push_back(cyc);
    end
    @(negedge clk);
    if (acked) begin
      prod_data = prod_data + 1;
      acked     = 1'b0;
    end
    if (src_req_o) begin
      if (wait_cnt == prod_delay) begin
        src_ack_i = 1'b1;
        src_din_i = prod_data;
        acked     = 1'b1;
        wait_cnt  = 0;
      end else begin
        src_ack_i = 1'b0;
        wait_cnt++;
      end
    end else begin
      src_ack_i = stray_ack;
      src_din_i = 32'hDEAD_BEEF;
      wait_cnt  = 0;
    end
  endtask

  task automatic wait_ack(input int port, input int budget, input string name);
    int n;
    n = 0;
    while (!bit_at(ack_o, port) && n < budget) begin
      tick();
      n++;
    end
    check(name, 64'(ack_o), 64'(N'(1) << port));
  endtask

  task automatic clear_logs();
    log_port.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic collect(input int want, input int budget);
    int n;
    n = 0;
    while (log_port.size() < want && n < budget) begin
      tick();
      n++;
    end
    check("collect_count", 64'(log_port.size()), 64'(want));
  endtask

  initial begin
    rst = 1'b1; req_i = '0; src_ack_i = 1'b0; src_din_i = '0;

    // Reset state.
    repeat (3) tick();
    check("rst_ack",   64'(ack_o),        64'(0));
    check("rst_sreq",  64'(src_req_o),    64'(0));
    check("rst_busy",  64'(busy_o),       64'(0));
    check("rst_grant", 64'(grant_idx_o),  64'(0));
    check("rst_dout",  64'(dout_o),       64'(0));
    check("rst_count", 64'(xfer_count_o), 64'(0));
    rst = 1'b0;
    tick();

    // Single requester, producer ready at once, data 0x5.
    prod_data = 32'h5;
    prod_delay = 0;
    req_i = 4'b0001;
    tick();
    check("single_sreq",  64'(src_req_o),   64'(1));
    check("single_grant", 64'(grant_idx_o), 64'(0));
    tick();
    check("single_ack",   64'(ack_o),        64'(4'b0001));
    check("single_dout",  64'(dout_o),       64'(32'h5));
    check("single_count", 64'(xfer_count_o), 64'(1));
    req_i = '0;
    tick();
    check("single_ack_gone", 64'(ack_o),  64'(0));
    check("single_idle",     64'(busy_o), 64'(0));
    tick();

    // All requesters held, data from 0: order 0,1,2,3,..., port k gets k, k+4, k+8.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    prod_data = '0;
    clear_logs();
    req_i = 4'b1111;
    collect(12, 100);
    req_i = '0;
    repeat (3) tick();
    for (int i = 0; i < log_port.size(); i++) begin
      check("rr_order", 64'(log_port[i]), 64'(i % 4));
      check("rr_data",  64'(log_data[i]), 64'(i));
      if (i > 0) check("rr_spacing", 64'(log_cyc[i] - log_cyc[i-1]), 64'(3));
    end

    // Slow producer: ack 10 cycles late, src_req held 11 cycles.
    prod_delay = 10;
    sreq_cycles = 0;
    req_i = 4'b0100;
    repeat (5) tick();
    check("slow_busy", 64'(busy_o),    64'(1));
    check("slow_sreq", 64'(src_req_o), 64'(1));
    check("slow_ack0", 64'(ack_o),     64'(0));
    wait_ack(2, 30, "slow_ack");
    check("slow_sreq_cycles", 64'(sreq_cycles), 64'(11));
    req_i = '0;
    repeat (3) tick();

    // Reset in FETCH aborts; stray producer ack afterwards is ignored.
    prod_delay = 5;
    req_i = 4'b0010;
    repeat (2) tick();
    check("abort_busy", 64'(busy_o), 64'(1));
    rst = 1'b1;
    tick();
    check("abort_ack",   64'(ack_o),        64'(0));
    check("abort_sreq",  64'(src_req_o),    64'(0));
    check("abort_busy0", 64'(busy_o),       64'(0));
    check("abort_count", 64'(xfer_count_o), 64'(0));
    check("abort_dout",  64'(dout_o),       64'(0));
    tick();
    rst = 1'b0;
    req_i = '0;
    tick();
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    repeat (2) tick();
    check("stray_count", 64'(xfer_count_o), 64'(0));
    check("stray_busy",  64'(busy_o),       64'(0));
    check("abort_no_ack_pulse", 64'(ack_seen), 64'(14));
    req_i = 4'b0011;
    tick();
    check("post_rst_grant", 64'(grant_idx_o), 64'(0));
    wait_ack(0, 20, "post_rst_ack0");
    req_i = 4'b0010;
    wait_ack(1, 20, "post_rst_ack1");
    req_i = '0;
    repeat (3) tick();

    // Granted port drops mid-FETCH while another port rises: transfer still completes.
    prod_delay = 3;
    req_i = 4'b1000;
    repeat (2) tick();
    req_i = 4'b0001;
    wait_ack(3, 20, "drop_ack");
    check("drop_count", 64'(xfer_count_o), 64'(3));
    check("drop_grant", 64'(grant_idx_o),  64'(3));
    wait_ack(0, 20, "drop_next_ack");
    check("drop_next_count", 64'(xfer_count_o), 64'(4));
    req_i = '0;
    repeat (3) tick();
    check("drop_idle", 64'(busy_o), 64'(0));

    // Lone requester held: regranted every 3 cycles.
    prod_delay = 0;
    clear_logs();
    req_i = 4'b0010;
    collect(4, 40);
    req_i = '0;
    repeat (3) tick();
    for (int i = 0; i < log_port.size(); i++) begin
      check("lone_port", 64'(log_port[i]), 64'(1));
      if (i > 0) check("lone_spacing", 64'(log_cyc[i] - log_cyc[i-1]), 64'(3));
    end
    check("lone_count", 64'(xfer_count_o), 64'(8));

    // Counter wrap from 0xFFFFFFFF.
    force dut.xfer_count_q = 32'hFFFF_FFFF;
    cnt_preload = 1'b1;
    tick();
    release dut.xfer_count_q;
    cnt_preload = 1'b0;
    check("wrap_preload", 64'(xfer_count_o), 64'(32'hFFFF_FFFF));
    req_i = 4'b0001;
    wait_ack(0, 20, "wrap_ack");
    check("wrap_count", 64'(xfer_count_o), 64'(0));
    req_i = '0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_shared_src_arbiter
